bt_debounce_dev: RTL and testbench

- Memory-mapped push-button peripheral sitting between the raw board button pin and the CPU read-data mux at the button slot of the address decoder.
- Synchronises and debounces the raw button and keeps sticky press/release flags plus a saturating press counter.
- Software reads status as one 32-bit word and clears flags or the counter by writing through the decoder's write enable.

---
 rtl/bt_debounce_dev.sv | 99 +++++++++
 tb/tb_bt_debounce_dev.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/bt_debounce_dev.sv
// Memory-mapped push-button peripheral: two-flop synchroniser, counter-based
// debouncer, sticky press/release flags and a saturating press counter.
// Status is read as one 32-bit word. Writing 1 to d[1], d[2] or d[3] clears
// the press flag, the release flag or the press counter.
module bt_debounce_dev #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        bt_in,
    input  logic        we,
    input  logic [31:0] d,
    output logic [31:0] q,
    output logic        irq
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             bt_s1;
    logic             bt_s2;
    logic             db;
    logic [CNT_W-1:0] cnt;
    logic             press_flag;
    logic             release_flag;
    logic [7:0]       press_cnt;

    logic             flip;
    logic             rise;
    logic             fall;
    logic             clr_press;
    logic             clr_release;
    logic             clr_cnt;
    logic [7:0]       cnt_base;
    logic [7:0]       press_cnt_next;
    logic             unused_d;

    // Bring the asynchronous button level into the clock domain
    always_ff @(posedge clk) begin
        if (reset) begin
            bt_s1 <= 1'b0;
            bt_s2 <= 1'b0;
        end else begin
            bt_s1 <= bt_in;
            bt_s2 <= bt_s1;
        end
    end

    // Flip events are decoded from the next-state condition so that the
    // flags and the counter update on the same edge as db
    always_comb begin
        flip        = (bt_s2 != db) && (cnt == CNT_LAST);
        rise        = flip && !db;
        fall        = flip && db;
        clr_press   = we && d[1];
        clr_release = we && d[2];
        clr_cnt     = we && d[3];
        // Clear first, then count a coincident press, so no press is lost
        cnt_base       = clr_cnt ? '0 : press_cnt;
        press_cnt_next = cnt_base;
        if (rise && (cnt_base != 8'hFF)) begin
            press_cnt_next = cnt_base + 8'd1;
        end
    end

    // Accept a new level only after it persists for DEBOUNCE_CYCLES cycles
    always_ff @(posedge clk) begin
        if (reset) begin
            db  <= 1'b0;
            cnt <= '0;
        end else if (bt_s2 == db) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            db  <= bt_s2;
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Sticky flags and saturating press counter; a coincident event beats a clear
    always_ff @(posedge clk) begin
        if (reset) begin
            press_flag   <= 1'b0;
            release_flag <= 1'b0;
            press_cnt    <= '0;
        end else begin
            press_flag   <= rise | (press_flag & ~clr_press);
            release_flag <= fall | (release_flag & ~clr_release);
            press_cnt    <= press_cnt_next;
        end
    end

    assign unused_d = ^{d[31:4], d[0]};

    assign q   = {16'h0000, press_cnt, 5'b00000, release_flag, press_flag, db};
    assign irq = press_flag;

endmodule

// File: tb/tb_bt_debounce_dev.sv
// Directed bench for bt_debounce_dev with DEBOUNCE_CYCLES=4.
// Edge numbering: inputs set just after edge k are first sampled at edge k+1;
// a value "at edge k" is the one observed 1 ns after edge k.
module tb_bt_debounce_dev;

    logic        clk;
    logic        reset;
    logic        bt_in;
    logic        we;
    logic [31:0] d;
    logic [31:0] q;
    logic        irq;

    int compared;
    int mismatched;

    bt_debounce_dev #(
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bt_in (bt_in),
        .we    (we),
        .d     (d),
        .q     (q),
        .irq   (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n edges; return 1 ns after the last one
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Single-cycle register write
    task automatic write(input logic [31:0] val);
        we = 1'b1;
        d  = val;
        step(1);
        we = 1'b0;
        d  = '0;
    endtask

    // One clean press followed by a clean release (7 edges each way)
    task automatic press_release();
        bt_in = 1'b1;
        step(7);
        bt_in = 1'b0;
        step(7);
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        reset = 1'b1;
        bt_in = 1'b0;
        we    = 1'b0;
        d     = '0;
        step(3);

        // Reset state; reset overrides a write
        we = 1'b1;
        d  = 32'h0000_000E;
        step(1);
        check("reset_q", q, 32'h0);
        check("reset_irq", {31'b0, irq}, 32'h0);

        // Clean press: bt_in goes high at edge 0
        we    = 1'b0;
        d     = '0;
        reset = 1'b0;
        bt_in = 1'b1;
        step(5);
        check("press_edge5_q", q, 32'h0);
        check("press_edge5_irq", {31'b0, irq}, 32'h0);
        step(1);
        check("press_edge6_q", q, 32'h0000_0103);
        check("press_edge6_irq", {31'b0, irq}, 32'h1);

        // Release
        bt_in = 1'b0;
        step(5);
        check("release_edge5_q", q, 32'h0000_0103);
        step(1);
        check("release_edge6_q", q, 32'h0000_0106);

        // Write with none of d[3:1] set has no effect
        write(32'hFFFF_FFF1);
        check("noop_write_q", q, 32'h0000_0106);

        write(32'h0000_0006);
        check("clear_flags_q", q, 32'h0000_0100);
        check("clear_flags_irq", {31'b0, irq}, 32'h0);
        write(32'h0000_0008);
        check("clear_cnt_q", q, 32'h0);

        // Bounce rejection: 3-cycle high pulses never reach the threshold
        for (int i = 0; i < 20; i++) begin
            bt_in = ((i % 4) != 3);
            step(1);
            check("bounce_q", q, 32'h0);
            check("bounce_irq", {31'b0, irq}, 32'h0);
        end
        bt_in = 1'b0;
        step(8);
        check("bounce_settle_q", q, 32'h0);

        // Saturation
        for (int i = 0; i < 255; i++) begin
            press_release();
        end
        check("sat_255_q", q, 32'h0000_FF06);
        for (int i = 0; i < 5; i++) begin
            press_release();
        end
        check("sat_260_q", q, 32'h0000_FF06);
        check("sat_260_irq", {31'b0, irq}, 32'h1);

        // Clear/event collision: preload press_cnt=5 with flags cleared
        write(32'h0000_000E);
        check("collide_pre_clear_q", q, 32'h0);
        for (int i = 0; i < 5; i++) begin
            press_release();
        end
        write(32'h0000_0006);
        check("collide_preload_q", q, 32'h0000_0500);
        bt_in = 1'b1;
        step(5);
        check("collide_edge5_q", q, 32'h0000_0500);
        we = 1'b1;
        d  = 32'h0000_000E;
        step(1);
        we = 1'b0;
        d  = '0;
        check("collide_press_q", q, 32'h0000_0103);
        check("collide_press_irq", {31'b0, irq}, 32'h1);

        // Release flag clear coinciding with the fall
        bt_in = 1'b0;
        step(5);
        we = 1'b1;
        d  = 32'h0000_0004;
        step(1);
        we = 1'b0;
        d  = '0;
        check("collide_release_q", q, 32'h0000_0106);

        // Reset mid-debounce: bt_in high at edge 0, reset sampled at edge 5
        bt_in = 1'b1;
        step(4);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        check("midreset_edge5_q", q, 32'h0);
        check("midreset_edge5_irq", {31'b0, irq}, 32'h0);
        step(5);
        check("midreset_edge10_q", q, 32'h0);
        step(1);
        check("midreset_edge11_q", q, 32'h0000_0103);
        check("midreset_edge11_irq", {31'b0, irq}, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
